// File: rtl/lcd_msg_scheduler.sv
// Round-robin scheduler that shares the LCD message-select input between requesters.
// Optional urgent requester 0 preemption is enabled by defining LCD_SCHED_PREEMPT_EN.
module lcd_msg_scheduler #(
    parameter int           NUM_REQ     = 4,
    parameter int           HOLD_CYCLES = 100000000,
    parameter logic [3:0]   IDLE_MSG    = 4'd0
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic [NUM_REQ-1:0]     iReq,
    input  logic [4*NUM_REQ-1:0]   iReq_msg,
    output logic [3:0]             oMensaje,
    output logic [NUM_REQ-1:0]     oGrant,
    output logic                   oBusy,
    output logic                   oDone,
    output logic [NUM_REQ-1:0]     oErr,
    output logic                   dbg_state
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {S_IDLE, S_SHOW} state_t;

    state_t               state, state_n;
    logic [NUM_REQ-1:0]   pending, pending_n;
    logic [3:0]           msg_q [NUM_REQ];
    logic [3:0]           msg_n [NUM_REQ];
    logic [PW-1:0]        rr_ptr, ptr_n;
    logic [CW-1:0]        counter, counter_n;
    logic [3:0]           mensaje_n;
    logic [NUM_REQ-1:0]   grant_n, err_n, req_ok, set_mask, clr_mask;
    logic                 done_n;
    logic                 win_found;
    logic [PW-1:0]        win_idx;
    logic                 preempt;

    // Codes 2 and 15 have no display text and are rejected.
    always_comb begin
        req_ok = '0;
        err_n  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (iReq[k]) begin
                if (iReq_msg[4*k +: 4] == 4'd2 || iReq_msg[4*k +: 4] == 4'd15)
                    err_n[k] = 1'b1;
                else
                    req_ok[k] = 1'b1;
            end
        end
    end

`ifdef LCD_SCHED_PREEMPT_EN
    assign preempt = (state == S_SHOW) && req_ok[0];
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!win_found && pending[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_n   = state;
        counter_n = counter;
        mensaje_n = oMensaje;
        ptr_n     = rr_ptr;
        grant_n   = '0;
        done_n    = 1'b0;
        clr_mask  = '0;
        if (preempt) begin
            mensaje_n  = iReq_msg[3:0];
            grant_n[0] = 1'b1;
            counter_n  = HOLD_LOAD;
            ptr_n      = PW'(1);
        end else if ((state == S_IDLE || counter == '0) && win_found) begin
            mensaje_n         = msg_q[win_idx];
            grant_n[win_idx]  = 1'b1;
            clr_mask[win_idx] = 1'b1;
            counter_n         = HOLD_LOAD;
            state_n           = S_SHOW;
            ptr_n             = (win_idx == PW'(NUM_REQ - 1)) ? '0 : PW'(win_idx + 1'b1);
        end else if (state == S_SHOW) begin
            if (counter == '0) begin
                mensaje_n = IDLE_MSG;
                done_n    = 1'b1;
                state_n   = S_IDLE;
            end else begin
                counter_n = counter - 1'b1;
            end
        end
    end

    // A new request beats a same-cycle grant clear; a preempting request is consumed directly.
    always_comb begin
        set_mask = req_ok;
        if (preempt)
            set_mask[0] = 1'b0;
        pending_n = (pending & ~clr_mask) | set_mask;
        for (int k = 0; k < NUM_REQ; k++)
            msg_n[k] = set_mask[k] ? iReq_msg[4*k +: 4] : msg_q[k];
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= S_IDLE;
            pending  <= '0;
            rr_ptr   <= '0;
            counter  <= '0;
            oMensaje <= IDLE_MSG;
            oGrant   <= '0;
            oDone    <= 1'b0;
            oErr     <= '0;
            for (int k = 0; k < NUM_REQ; k++)
                msg_q[k] <= '0;
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            rr_ptr   <= ptr_n;
            counter  <= counter_n;
            oMensaje <= mensaje_n;
            oGrant   <= grant_n;
            oDone    <= done_n;
            oErr     <= err_n;
            for (int k = 0; k < NUM_REQ; k++)
                msg_q[k] <= msg_n[k];
        end
    end

    assign oBusy     = (state == S_SHOW);
    assign dbg_state = state;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Scoreboard bench for lcd_msg_scheduler: expected grant/done/err events are queued by
// the stimulus and popped by a monitor that also tracks display length and idle output.
module tb_lcd_msg_scheduler;

    localparam int N    = 4;
    localparam int HOLD = 8;

    logic         iCLK = 1'b0;
    logic         iRST_N = 1'b0;
    logic [N-1:0] iReq = '0;
    logic [4*N-1:0] iReq_msg = '0;
    logic [3:0]   oMensaje;
    logic [N-1:0] oGrant;
    logic         oBusy;
    logic         oDone;
    logic [N-1:0] oErr;
    logic         dbg_state;

    lcd_msg_scheduler #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .IDLE_MSG(4'd0)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iReq(iReq), .iReq_msg(iReq_msg),
        .oMensaje(oMensaje), .oGrant(oGrant), .oBusy(oBusy), .oDone(oDone),
        .oErr(oErr), .dbg_state(dbg_state)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    // Event word: {kind[1:0], preempt, 0, mask[3:0], code[3:0]}; kind 1=grant 2=done 3=err.
    function automatic logic [11:0] ev(input logic [1:0] kind, input logic pre,
                                       input logic [3:0] mask, input logic [3:0] code);
        return {kind, pre, 1'b0, mask, code};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen with empty expected queue at %0t", name, $time);
    endtask

    // Monitor
    logic        active = 1'b0;
    int          cur_len = 0;
    logic [3:0]  cur_code = 4'd0;

    always @(negedge iCLK) begin
        logic [11:0] e;
        if (!iRST_N) begin
            active  = 1'b0;
            cur_len = 0;
        end else begin
            if (oErr != '0) begin
                if (exp_q.size() == 0) unexpected("err_event");
                else begin
                    e = exp_q.pop_front();
                    check("err_event", 32'(ev(2'd3, 1'b0, oErr, 4'd0)), 32'(e));
                end
            end
            if (oGrant != '0) begin
                if (exp_q.size() == 0) unexpected("grant_event");
                else begin
                    e = exp_q.pop_front();
                    check("grant_event", 32'(ev(2'd1, e[9], oGrant, oMensaje)), 32'(e));
                    if (active && !e[9]) check("hold_len", 32'(cur_len), 32'(HOLD));
                end
                active   = 1'b1;
                cur_len  = 1;
                cur_code = oMensaje;
            end else if (oDone) begin
                if (exp_q.size() == 0) unexpected("done_event");
                else begin
                    e = exp_q.pop_front();
                    check("done_event", 32'(ev(2'd2, 1'b0, 4'd0, 4'd0)), 32'(e));
                end
                check("done_after_show", 32'(active), 32'd1);
                if (active) check("hold_len", 32'(cur_len), 32'(HOLD));
                active = 1'b0;
            end else if (active) begin
                cur_len++;
            end
            check("busy", 32'(oBusy), 32'(active));
            check("mensaje", 32'(oMensaje), 32'(active ? cur_code : 4'd0));
        end
    end

    // Driver tasks; each starts and ends just after a rising edge.
    task automatic issue(input logic [N-1:0] mask, input logic [4*N-1:0] codes);
        iReq     = mask;
        iReq_msg = codes;
        @(posedge iCLK);
        #1;
        iReq     = '0;
        iReq_msg = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mensaje"}, 32'(oMensaje), 32'd0);
        check({tag, "_grant"},   32'(oGrant),   32'd0);
        check({tag, "_busy"},    32'(oBusy),    32'd0);
        check({tag, "_done"},    32'(oDone),    32'd0);
        check({tag, "_err"},     32'(oErr),     32'd0);
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge iCLK);
        @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || oBusy) && n < budget) begin
            @(posedge iCLK);
            n++;
        end
        repeat (2) @(posedge iCLK);
        #1;
        check("quiet_timeout", 32'(n >= budget), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Single request: pending one cycle later, shown the cycle after.
        do_reset();
        exp_q.push_back(ev(2'd1, 1'b0, 4'b0010, 4'd5));
        exp_q.push_back(ev(2'd2, 1'b0, 4'd0, 4'd0));
        issue(4'b0010, 16'h0050);
        @(negedge iCLK);
        check("latency_no_grant_yet", 32'(oGrant), 32'd0);
        @(negedge iCLK);
        check("latency_grant", 32'(oGrant), 32'b0010);
        check("latency_mensaje", 32'(oMensaje), 32'd5);
        wait_quiet(100);

        // All four at once: round-robin from pointer 0, back-to-back, single done.
        do_reset();
        exp_q.push_back(ev(2'd1, 1'b0, 4'b0001, 4'd1));
        exp_q.push_back(ev(2'd1, 1'b0, 4'b0010, 4'd3));
        exp_q.push_back(ev(2'd1, 1'b0, 4'b0100, 4'd4));
        exp_q.push_back(ev(2'd1, 1'b0, 4'b1000, 4'd6));
        exp_q.push_back(ev(2'd2, 1'b0, 4'd0, 4'd0));
        issue(4'b1111, 16'h6431);
        wait_quiet(100);

        // Invalid codes rejected, nothing displayed.
        do_reset();
        exp_q.push_back(ev(2'd3, 1'b0, 4'b0100, 4'd0));
        exp_q.push_back(ev(2'd3, 1'b0, 4'b1000, 4'd0));
        issue(4'b0100, 16'h0200);
        issue(4'b1000, 16'hF000);
        wait_quiet(50);
        check("invalid_busy", 32'(oBusy), 32'd0);
        check("invalid_mensaje", 32'(oMensaje), 32'd0);

        // Repeat request during SHOW overwrites; shown once.
        do_reset();
        exp_q.push_back(ev(2'd1, 1'b0, 4'b0010, 4'd5));
        exp_q.push_back(ev(2'd1, 1'b0, 4'b0100, 4'd9));
        exp_q.push_back(ev(2'd2, 1'b0, 4'd0, 4'd0));
        issue(4'b0010, 16'h0050);
        repeat (2) @(posedge iCLK);
        #1;
        issue(4'b0100, 16'h0700);
        issue(4'b0100, 16'h0900);
        wait_quiet(100);

        // New request lands on the same edge that grants and clears that requester.
        do_reset();
        exp_q.push_back(ev(2'd1, 1'b0, 4'b0010, 4'd5));
        exp_q.push_back(ev(2'd1, 1'b0, 4'b0100, 4'd7));
        exp_q.push_back(ev(2'd1, 1'b0, 4'b0100, 4'd9));
        exp_q.push_back(ev(2'd2, 1'b0, 4'd0, 4'd0));
        issue(4'b0010, 16'h0050);
        issue(4'b0100, 16'h0700);
        repeat (7) @(posedge iCLK);
        #1;
        issue(4'b0100, 16'h0900);
        wait_quiet(100);

        // Reset mid-SHOW with requesters 2 and 3 pending: everything dropped.
        do_reset();
        exp_q.push_back(ev(2'd1, 1'b0, 4'b0010, 4'd5));
        issue(4'b0010, 16'h0050);
        issue(4'b1100, 16'h4300);
        repeat (2) @(posedge iCLK);
        #1;
        check("pre_abort_busy", 32'(oBusy), 32'd1);
        iRST_N = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        repeat (20) @(posedge iCLK);
        #1;
        check("abort_nothing_shown", 32'(exp_q.size()), 32'd0);
        check("abort_idle_busy", 32'(oBusy), 32'd0);

`ifdef LCD_SCHED_PREEMPT_EN
        // Urgent requester 0 preempts requester 2; code 8 is not resumed.
        do_reset();
        exp_q.push_back(ev(2'd1, 1'b0, 4'b0100, 4'd8));
        exp_q.push_back(ev(2'd1, 1'b1, 4'b0001, 4'd13));
        exp_q.push_back(ev(2'd2, 1'b0, 4'd0, 4'd0));
        issue(4'b0100, 16'h0800);
        repeat (2) @(posedge iCLK);
        #1;
        issue(4'b0001, 16'h000D);
        wait_quiet(100);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
